// File: rtl/median_column_feeder.sv
// Raster pixel stream to vertically aligned (row-2, row-1, row) triplets for the median sorter.
// Optional macro BORDER_REPLICATE_EN: rows 0 and 1 also emit triplets with the top edge replicated.
module median_column_feeder #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  localparam int COL_W = $clog2(IMG_WIDTH),
  localparam int ROW_W = $clog2(IMG_HEIGHT)
) (
  input  logic             clk_100M,
  input  logic             rst_p,
  input  logic             frame_start,
  input  logic [7:0]       pixel_in,
  input  logic             pixel_valid,
  output logic [7:0]       pixel_1,
  output logic [7:0]       pixel_2,
  output logic [7:0]       pixel_3,
  output logic             triplet_valid,
  output logic [COL_W-1:0] col_out,
  output logic [ROW_W-1:0] row_out,
  output logic             frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM
  } state_t;

  state_t state_q, state_d;
  state_t cur_state;

  logic [COL_W-1:0] col_q, col_d, cur_col;
  logic [ROW_W-1:0] row_q, row_d, cur_row;

  logic [7:0] pixel_1_q, pixel_1_d;
  logic [7:0] pixel_2_q, pixel_2_d;
  logic [7:0] pixel_3_q, pixel_3_d;
  logic       triplet_valid_q, triplet_valid_d;
  logic       frame_done_q, frame_done_d;
  logic [COL_W-1:0] col_out_q, col_out_d;
  logic [ROW_W-1:0] row_out_q, row_out_d;

  logic [7:0] lb_a [IMG_WIDTH];
  logic [7:0] lb_b [IMG_WIDTH];
  logic [7:0] rd_a, rd_b;

  logic accept;
  logic last_col, last_row;

  // A frame_start overrides the current position so the same-cycle pixel lands at (0,0).
  always_comb begin
    cur_state = frame_start ? FILL : state_q;
    cur_col   = frame_start ? '0 : col_q;
    cur_row   = frame_start ? '0 : row_q;
    accept    = pixel_valid && (cur_state != IDLE);
    last_col  = (cur_col == COL_W'(IMG_WIDTH - 1));
    last_row  = (cur_row == ROW_W'(IMG_HEIGHT - 1));
  end

  assign rd_a = lb_a[cur_col];
  assign rd_b = lb_b[cur_col];

  always_comb begin
    state_d = cur_state;
    col_d   = cur_col;
    row_d   = cur_row;
    if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = cur_row + ROW_W'(1);
        if (cur_state == FILL && cur_row == ROW_W'(1)) begin
          state_d = STREAM;
        end
        if (cur_state == STREAM && last_row) begin
          state_d = IDLE;
          row_d   = '0;
        end
      end else begin
        col_d = cur_col + COL_W'(1);
      end
    end
  end

  // Data outputs hold between accepted pixels; only the strobes drop.
  always_comb begin
    pixel_1_d       = pixel_1_q;
    pixel_2_d       = pixel_2_q;
    pixel_3_d       = pixel_3_q;
    col_out_d       = col_out_q;
    row_out_d       = row_out_q;
    triplet_valid_d = 1'b0;
    frame_done_d    = 1'b0;
    if (accept) begin
      if (cur_state == STREAM) begin
        triplet_valid_d = 1'b1;
        pixel_1_d       = rd_b;
        pixel_2_d       = rd_a;
        pixel_3_d       = pixel_in;
        col_out_d       = cur_col;
        row_out_d       = cur_row;
        frame_done_d    = last_col && last_row;
      end
`ifdef BORDER_REPLICATE_EN
      else begin
        triplet_valid_d = 1'b1;
        pixel_3_d       = pixel_in;
        col_out_d       = cur_col;
        row_out_d       = cur_row;
        if (cur_row == '0) begin
          pixel_1_d = pixel_in;
          pixel_2_d = pixel_in;
        end else begin
          pixel_1_d = rd_a;
          pixel_2_d = rd_a;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk_100M or posedge rst_p) begin
    if (rst_p) begin
      state_q         <= IDLE;
      col_q           <= '0;
      row_q           <= '0;
      pixel_1_q       <= '0;
      pixel_2_q       <= '0;
      pixel_3_q       <= '0;
      col_out_q       <= '0;
      row_out_q       <= '0;
      triplet_valid_q <= 1'b0;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      col_q           <= col_d;
      row_q           <= row_d;
      pixel_1_q       <= pixel_1_d;
      pixel_2_q       <= pixel_2_d;
      pixel_3_q       <= pixel_3_d;
      col_out_q       <= col_out_d;
      row_out_q       <= row_out_d;
      triplet_valid_q <= triplet_valid_d;
      frame_done_q    <= frame_done_d;
    end
  end

  // Nonblocking writes give read-before-write: row-1 shifts into row-2 as the new pixel lands.
  always_ff @(posedge clk_100M) begin
    if (accept) begin
      lb_b[cur_col] <= rd_a;
      lb_a[cur_col] <= pixel_in;
    end
  end

  assign pixel_1       = pixel_1_q;
  assign pixel_2       = pixel_2_q;
  assign pixel_3       = pixel_3_q;
  assign triplet_valid = triplet_valid_q;
  assign frame_done    = frame_done_q;
  assign col_out       = col_out_q;
  assign row_out       = row_out_q;

endmodule

// File: tb/tb_median_column_feeder.sv
// Bench for median_column_feeder on a 4x4 image; an image-array model checks every cycle.
// Build with BORDER_REPLICATE_EN defined to check the edge-replicating variant.
module tb_median_column_feeder;

  localparam int W = 4;
  localparam int H = 4;
`ifdef BORDER_REPLICATE_EN
  localparam int EXP_TRIP  = W * H;
  localparam int EXP_ABORT = 10 + W * H;
`else
  localparam int EXP_TRIP  = W * (H - 2);
  localparam int EXP_ABORT = 2 + W * (H - 2);
`endif

  logic       clk_100M = 1'b0;
  logic       rst_p = 1'b1;
  logic       frame_start = 1'b0;
  logic [7:0] pixel_in = 8'h00;
  logic       pixel_valid = 1'b0;
  logic [7:0] pixel_1, pixel_2, pixel_3;
  logic       triplet_valid, frame_done;
  logic [1:0] col_out, row_out;

  int n_checks = 0;
  int n_errors = 0;
  int trip_cnt = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  median_column_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk_100M      (clk_100M),
    .rst_p         (rst_p),
    .frame_start   (frame_start),
    .pixel_in      (pixel_in),
    .pixel_valid   (pixel_valid),
    .pixel_1       (pixel_1),
    .pixel_2       (pixel_2),
    .pixel_3       (pixel_3),
    .triplet_valid (triplet_valid),
    .col_out       (col_out),
    .row_out       (row_out),
    .frame_done    (frame_done)
  );

  always #5 clk_100M = ~clk_100M;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the frame as a 2-D image, the pixel's raster index gives its (row, col).
  logic [7:0] img [H][W];
  logic [7:0] m_p1 = 8'h00, m_p2 = 8'h00, m_p3 = 8'h00;
  logic       m_valid = 1'b0, m_done = 1'b0;
  logic [1:0] m_col = 2'd0, m_row = 2'd0;
  int         m_idx = 0;
  bit         m_active = 1'b0;
  int         mr, mc;

  always @(posedge clk_100M or posedge rst_p) begin
    if (rst_p) begin
      m_p1 = 8'h00; m_p2 = 8'h00; m_p3 = 8'h00;
      m_valid = 1'b0; m_done = 1'b0; m_col = 2'd0; m_row = 2'd0;
      m_idx = 0; m_active = 1'b0;
    end else begin
      m_valid = 1'b0;
      m_done  = 1'b0;
      if (frame_start) begin
        m_active = 1'b1;
        m_idx    = 0;
      end
      if (pixel_valid && m_active) begin
        mr = m_idx / W;
        mc = m_idx % W;
        img[mr][mc] = pixel_in;
        if (mr >= 2) begin
          m_p1 = img[mr-2][mc]; m_p2 = img[mr-1][mc]; m_p3 = pixel_in; m_valid = 1'b1;
        end
`ifdef BORDER_REPLICATE_EN
        else if (mr == 0) begin
          m_p1 = pixel_in; m_p2 = pixel_in; m_p3 = pixel_in; m_valid = 1'b1;
        end else begin
          m_p1 = img[0][mc]; m_p2 = img[0][mc]; m_p3 = pixel_in; m_valid = 1'b1;
        end
`endif
        if (m_valid) begin
          m_col  = 2'(mc);
          m_row  = 2'(mr);
          m_done = (m_idx == W * H - 1);
        end
        m_idx++;
        if (m_idx == W * H) begin
          m_active = 1'b0;
          m_idx    = 0;
        end
      end
    end
  end

  always @(negedge clk_100M) begin
    if (chk_en) begin
      check_output("triplet_valid", 32'(triplet_valid), 32'(m_valid));
      check_output("frame_done", 32'(frame_done), 32'(m_done));
      check_output("pixel_1", 32'(pixel_1), 32'(m_p1));
      check_output("pixel_2", 32'(pixel_2), 32'(m_p2));
      check_output("pixel_3", 32'(pixel_3), 32'(m_p3));
      check_output("col_out", 32'(col_out), 32'(m_col));
      check_output("row_out", 32'(row_out), 32'(m_row));
      if (triplet_valid === 1'b1) trip_cnt++;
      if (frame_done === 1'b1) done_cnt++;
    end
  end

  task automatic apply_stimulus(input logic fs, input logic pv, input logic [7:0] pix);
    frame_start = fs;
    pixel_valid = pv;
    pixel_in    = pix;
    @(posedge clk_100M);
    #1;
    frame_start = 1'b0;
    pixel_valid = 1'b0;
  endtask

  task automatic check_triplet(input string name, input logic [7:0] e1, input logic [7:0] e2,
                               input logic [7:0] e3);
    check_output({name, "_valid"}, 32'(triplet_valid), 32'd1);
    check_output({name, "_p1"}, 32'(pixel_1), 32'(e1));
    check_output({name, "_p2"}, 32'(pixel_2), 32'(e2));
    check_output({name, "_p3"}, 32'(pixel_3), 32'(e3));
  endtask

  task automatic feed_frame(input logic [7:0] base, input int gap, input int n_pix);
    logic [7:0] pix;
    logic [3:0] r4, c4;
    for (int i = 0; i < n_pix; i++) begin
      r4  = 4'(i / W);
      c4  = 4'(i % W);
      pix = base + {r4, c4};
      apply_stimulus(i == 0, 1'b1, pix);
      if (base == 8'h00 && pix == 8'h21) begin
        check_triplet("lit21", 8'h01, 8'h11, 8'h21);
        check_output("lit21_col", 32'(col_out), 32'd1);
        check_output("lit21_row", 32'(row_out), 32'd2);
      end
      if (base == 8'h00 && pix == 8'h32) check_output("lit32_done", 32'(frame_done), 32'd0);
      if (base == 8'h00 && pix == 8'h33) begin
        check_triplet("lit33", 8'h13, 8'h23, 8'h33);
        check_output("lit33_done", 32'(frame_done), 32'd1);
      end
      if (base == 8'h80 && pix == 8'hA0) check_triplet("litA0", 8'h80, 8'h90, 8'hA0);
`ifdef BORDER_REPLICATE_EN
      if (base == 8'h00 && pix == 8'h00) check_triplet("lit00", 8'h00, 8'h00, 8'h00);
      if (base == 8'h00 && pix == 8'h12) check_triplet("lit12", 8'h02, 8'h02, 8'h12);
`endif
      for (int g = 0; g < gap; g++) apply_stimulus(1'b0, 1'b0, pix);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0, d0;
    repeat (2) @(posedge clk_100M);
    #1;
    rst_p  = 1'b0;
    chk_en = 1'b1;
    check_output("reset_valid", 32'(triplet_valid), 32'd0);
    check_output("reset_p3", 32'(pixel_3), 32'd0);
    check_output("reset_col", 32'(col_out), 32'd0);

    // Pixels without frame_start after reset must be dropped.
    t0 = trip_cnt;
    for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 1'b1, 8'(8'h40 + i));
    apply_stimulus(1'b0, 1'b0, 8'h00);
    check_output("no_fs_trip_cnt", 32'(trip_cnt - t0), 32'd0);
    check_output("no_fs_row", 32'(row_out), 32'd0);

    // Full frame, continuous valid, then extra pixels that must be dropped.
    t0 = trip_cnt; d0 = done_cnt;
    feed_frame(8'h00, 0, W * H);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 8'h55);
    apply_stimulus(1'b0, 1'b0, 8'h00);
    check_output("full_trip_cnt", 32'(trip_cnt - t0), 32'(EXP_TRIP));
    check_output("full_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Alternating valid.
    t0 = trip_cnt; d0 = done_cnt;
    feed_frame(8'h00, 1, W * H);
    apply_stimulus(1'b0, 1'b0, 8'h00);
    check_output("gap_trip_cnt", 32'(trip_cnt - t0), 32'(EXP_TRIP));
    check_output("gap_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Abort at (row 2, col 2) with a new +0x80 frame.
    t0 = trip_cnt; d0 = done_cnt;
    feed_frame(8'h00, 0, 2 * W + 2);
    feed_frame(8'h80, 0, W * H);
    apply_stimulus(1'b0, 1'b0, 8'h00);
    check_output("abort_trip_cnt", 32'(trip_cnt - t0), 32'(EXP_ABORT));
    check_output("abort_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Asynchronous reset mid-stream, then a clean frame.
    feed_frame(8'h00, 0, 2 * W + 2);
    rst_p = 1'b1;
    #1;
    check_output("midrst_valid", 32'(triplet_valid), 32'd0);
    check_output("midrst_p1", 32'(pixel_1), 32'd0);
    check_output("midrst_p2", 32'(pixel_2), 32'd0);
    check_output("midrst_p3", 32'(pixel_3), 32'd0);
    check_output("midrst_col", 32'(col_out), 32'd0);
    check_output("midrst_row", 32'(row_out), 32'd0);
    @(posedge clk_100M);
    #1;
    rst_p = 1'b0;
    t0 = trip_cnt; d0 = done_cnt;
    feed_frame(8'h00, 0, W * H);
    apply_stimulus(1'b0, 1'b0, 8'h00);
    check_output("rerun_trip_cnt", 32'(trip_cnt - t0), 32'(EXP_TRIP));
    check_output("rerun_done_cnt", 32'(done_cnt - d0), 32'd1);

    repeat (2) apply_stimulus(1'b0, 1'b0, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
